// File: rtl/crack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crack_pkg
// Purpose  : Shared types and character constants for the RC4 cracking engine.
// Revision : 1.0 - initial release
// ============================================================================
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WAIT     = 3'd2,
        CHECK    = 3'd3,
        REPORT   = 3'd4,
        HOLD     = 3'd5,
        ACK_WAIT = 3'd6
    } check_state_t;

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Plaintext alphabet: lowercase letters and space only.
    function automatic logic is_legal_char(input logic [7:0] ch);
        return ((ch >= CHAR_A) && (ch <= CHAR_Z)) || (ch == CHAR_SPACE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/message_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : message_checker_if
// Purpose  : RAM read port and cracking-FSM handshake of the message checker.
// Revision : 1.0 - initial release
// ============================================================================
interface message_checker_if #(
    parameter int ADDR_W = 5
);
    logic              check_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              crack_ack;
    logic              test_finish;
    logic              test_message_valid;
    logic              test_message_invalid;
    logic [ADDR_W-1:0] bad_index;
    logic [2:0]        check_state;

    // master: the checker itself; slave: RAM plus cracking FSM side
    modport master (
        input  check_start, rd_data, crack_ack,
        output rd_addr, test_finish, test_message_valid, test_message_invalid,
               bad_index, check_state
    );

    modport slave (
        output check_start, rd_data, crack_ack,
        input  rd_addr, test_finish, test_message_valid, test_message_invalid,
               bad_index, check_state
    );
endinterface
`default_nettype wire

// File: rtl/message_checker.sv
`default_nettype none
// ============================================================================
// Module   : message_checker
// Purpose  : Scans the decrypted message RAM and reports valid/invalid.
// Revision : 1.0 - initial release
// ============================================================================
module message_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  wire logic          clk,
    input  wire logic          nreset,
    message_checker_if.master  bus
);
    import crack_pkg::*;

    localparam logic [ADDR_W-1:0] c_LAST_INDEX = ADDR_W'(MSG_LEN - 1);

    check_state_t      r_state;
    check_state_t      w_next_state;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_bad_index;
    logic              r_finish;
    logic              r_valid;
    logic              r_invalid;
    logic              w_legal;
    logic              w_last;

    assign w_legal = is_legal_char(bus.rd_data);
    assign w_last  = (r_index == c_LAST_INDEX);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (bus.check_start) w_next_state = READ;
            READ:     w_next_state = WAIT;
            WAIT:     w_next_state = CHECK;
            CHECK:    w_next_state = (!w_legal || w_last) ? REPORT : READ;
            REPORT:   w_next_state = HOLD;
            HOLD:     if (bus.crack_ack) w_next_state = ACK_WAIT;
            ACK_WAIT: if (!bus.crack_ack) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Result levels are set on the edge entering REPORT, so they are
    // already visible in the same cycle as the test_finish pulse.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_index     <= '0;
            r_bad_index <= '0;
            r_finish    <= 1'b0;
            r_valid     <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.check_start) r_index <= '0;
                end
                CHECK: begin
                    if (!w_legal) begin
                        r_bad_index <= r_index;
                        r_invalid   <= 1'b1;
                        r_finish    <= 1'b1;
                    end else if (w_last) begin
                        r_bad_index <= '0;
                        r_valid     <= 1'b1;
                        r_finish    <= 1'b1;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.crack_ack) begin
                        r_valid   <= 1'b0;
                        r_invalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_addr              = r_index;
    assign bus.test_finish          = r_finish;
    assign bus.test_message_valid   = r_valid;
    assign bus.test_message_invalid = r_invalid;
    assign bus.bad_index            = r_bad_index;
    assign bus.check_state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_message_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_message_checker
// Purpose  : Directed and random checks of message_checker against a scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_message_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic clk;
    logic nreset;
    logic [7:0] mem [MSG_LEN];
    int n_checks;
    int n_err;

    message_checker_if #(.ADDR_W(ADDR_W)) bus ();

    message_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: one edge of latency.
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [7:0] b);
        return (b == 8'd32) || (b >= "a" && b <= "z");
    endfunction

    // Reference: index of first illegal byte, -1 when the whole message is legal.
    function automatic int first_bad();
        for (int i = 0; i < MSG_LEN; i++)
            if (!legal(mem[i])) return i;
        return -1;
    endfunction

    task automatic fill_all(input logic [7:0] b);
        for (int i = 0; i < MSG_LEN; i++) mem[i] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " state"},   bus.check_state, 0);
        check({tag, " rd_addr"}, bus.rd_addr, 0);
        check({tag, " finish"},  bus.test_finish, 0);
        check({tag, " valid"},   bus.test_message_valid, 0);
        check({tag, " invalid"}, bus.test_message_invalid, 0);
        check({tag, " bad_idx"}, bus.bad_index, 0);
    endtask

    task automatic run_scan(input string tag, input bit early_ack, input bit extra_start);
        int exp_idx, exp_cyc, exp_valid, fin_cyc, max_addr, exp_max;
        exp_idx   = first_bad();
        exp_valid = (exp_idx < 0) ? 1 : 0;
        exp_cyc   = exp_valid ? 3 * MSG_LEN + 1 : 3 * exp_idx + 4;
        exp_max   = exp_valid ? MSG_LEN - 1 : exp_idx;
        @(negedge clk) bus.check_start = 1'b1;
        @(negedge clk) bus.check_start = 1'b0;
        if (early_ack) bus.crack_ack = 1'b1;
        fin_cyc  = -1;
        max_addr = 0;
        for (int cyc = 1; cyc <= 200 && fin_cyc < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (extra_start) bus.check_start = (cyc == 10);
            if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
            if (bus.test_finish) fin_cyc = cyc;
        end
        bus.check_start = 1'b0;
        check({tag, " finish cycle"}, fin_cyc, exp_cyc);
        if (fin_cyc < 0) begin
            bus.crack_ack = 1'b0;
            nreset = 1'b0;
            @(negedge clk) nreset = 1'b1;
            return;
        end
        check({tag, " state REPORT"}, bus.check_state, 4);
        check({tag, " valid"},   bus.test_message_valid, exp_valid);
        check({tag, " invalid"}, bus.test_message_invalid, 1 - exp_valid);
        check({tag, " bad_idx"}, bus.bad_index, exp_valid ? 0 : exp_idx);
        check({tag, " max rd_addr"}, max_addr, exp_max);
        @(negedge clk);
        check({tag, " state HOLD"}, bus.check_state, 5);
        check({tag, " finish pulse"}, bus.test_finish, 0);
        check({tag, " valid held"}, bus.test_message_valid, exp_valid);
        check({tag, " invalid held"}, bus.test_message_invalid, 1 - exp_valid);
        if (!early_ack) begin
            @(negedge clk);
            check({tag, " still HOLD"}, bus.check_state, 5);
            check({tag, " level held"}, bus.test_message_valid | bus.test_message_invalid, 1);
            bus.crack_ack = 1'b1;
        end
        @(negedge clk);
        check({tag, " state ACK_WAIT"}, bus.check_state, 6);
        check({tag, " levels cleared"}, bus.test_message_valid | bus.test_message_invalid, 0);
        bus.crack_ack = 1'b0;
        @(negedge clk);
        check({tag, " back IDLE"}, bus.check_state, 0);
    endtask

    initial begin
        string s;
        logic [7:0] b;
        logic [7:0] bnd [7];
        n_checks = 0;
        n_err    = 0;
        nreset   = 1'b0;
        bus.check_start = 1'b0;
        bus.crack_ack   = 1'b0;
        fill_all(8'h20);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        nreset = 1'b1;

        // Normal valid plaintext.
        s = "attack at dawn";
        for (int i = 0; i < MSG_LEN; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
        run_scan("dawn", 1'b0, 1'b0);

        // Illegal first byte.
        fill_all("z");
        mem[0] = 8'h41;
        run_scan("byte0", 1'b0, 1'b0);

        // Illegal last byte.
        fill_all("z");
        mem[31] = 8'h7B;
        run_scan("byte31", 1'b0, 1'b0);

        // Boundary characters at byte 5.
        bnd[0] = 8'h60; bnd[1] = 8'h61; bnd[2] = 8'h7A; bnd[3] = 8'h7B;
        bnd[4] = 8'h1F; bnd[5] = 8'h20; bnd[6] = 8'h21;
        for (int k = 0; k < 7; k++) begin
            fill_all("a");
            mem[5] = bnd[k];
            run_scan($sformatf("bnd%02h", bnd[k]), 1'b0, 1'b0);
        end

        // Extra start mid-scan and ack held from cycle 1.
        fill_all("q");
        run_scan("early_ack", 1'b1, 1'b1);

        // Reset in the middle of a scan.
        fill_all(8'h20);
        @(negedge clk) bus.check_start = 1'b1;
        @(negedge clk) bus.check_start = 1'b0;
        repeat (39) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        nreset = 1'b1;
        @(negedge clk);
        check("midreset stays IDLE", bus.check_state, 0);
        run_scan("after_reset", 1'b0, 1'b0);

        // Random messages, mostly legal with sparse illegal bytes.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if ($urandom_range(0, 99) < 3) begin
                    do b = 8'($urandom_range(0, 255)); while (legal(b));
                end else begin
                    int k;
                    k = $urandom_range(0, 26);
                    b = (k == 26) ? 8'h20 : 8'(8'h61 + k);
                end
                mem[i] = b;
            end
            run_scan($sformatf("rand%0d", t), t[0], 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/message_checker.md
# message_checker

Plaintext validity checker for the RC4 cracking engine. It sits between the decrypted-message RAM, written by the RC4 decrypt stage, and the cracking FSM. On each start pulse it scans the decrypted message byte by byte and stops at the first illegal character. It then reports valid or invalid to the cracking FSM through a level/acknowledge handshake.

## Interface
- MSG_LEN, 32: message length in bytes, ≥1
- ADDR_W, 5: RAM address width, equal to clog2(MSG_LEN)
- clk  in  1  system clock
- nreset  in  1  reset, synchronous, active-low
- check_start  in  1  one-cycle pulse from the decrypt stage; the decrypted RAM is complete
- rd_addr  out  ADDR_W  decrypted-RAM read address
- rd_data  in  8  decrypted-RAM read data
- crack_ack  in  1  acknowledge from the cracking FSM
- test_finish  out  1  one-cycle pulse; the result is available
- test_message_valid  out  1  every byte is legal; held until acknowledged
- test_message_invalid  out  1  an illegal byte was found; held until acknowledged
- bad_index  out  ADDR_W  index of the first illegal byte; 0 when the message is valid
- check_state  out  3  current state, for debug

## Operation
- Legal byte: 0x61–0x7A ('a'–'z') or 0x20 (space). All other values are illegal, including 0x00 and 0x7B–0xFF.
- States:
  - IDLE: if check_start=1, clear the index to 0 and go to READ. Otherwise stay.
  - READ: drive rd_addr=index, go to WAIT.
  - WAIT: hold rd_addr; covers the synchronous RAM read latency. Go to CHECK.
  - CHECK: classify rd_data.
    - Illegal: bad_index←index, result=invalid, go to REPORT.
    - Legal and index=MSG_LEN-1: result=valid, go to REPORT.
    - Otherwise: index+1, go to READ.
  - REPORT: test_finish=1 for this cycle only; go to HOLD.
  - HOLD: the valid/invalid level stays asserted. When crack_ack=1, clear both levels and go to ACK_WAIT.
  - ACK_WAIT: when crack_ack=0, go to IDLE.
- test_message_valid/invalid are registered. They are asserted on the edge that enters REPORT and stay high through REPORT and HOLD. They are never both high.
- The index counter is ADDR_W bits wide and never wraps; the terminal compare against MSG_LEN-1 ends the scan.
- check_start outside IDLE is ignored and not queued.
- crack_ack in IDLE, READ, WAIT, CHECK or REPORT is ignored.
- Reset values, all outputs 0: rd_addr=0, test_finish=0, test_message_valid=0, test_message_invalid=0, bad_index=0, check_state=IDLE.
- Reset mid-scan or mid-handshake: the next cycle is IDLE and all result levels are cleared.

## Timing
- check_start sampled at edge 0. Byte i: READ in cycle 3i+1, WAIT in 3i+2, CHECK in 3i+3.
- Illegal byte i: test_finish high in cycle 3i+4.
- All bytes legal: test_finish high in cycle 3·MSG_LEN+1, i.e. cycle 97 for 32 bytes.
- rd_data is sampled only in CHECK, two edges after the address is driven.
- Handshake with the cracking FSM:
  - The result level is visible no later than the test_finish cycle.
  - The cracking FSM sees test_finish, samples the level one cycle later, and raises crack_ack.
  - The block drops the level on the first edge where crack_ack=1.
  - The cracking FSM drops crack_ack after it sees the level low.
  - The block returns to IDLE on the first edge where crack_ack=0.
- Minimum spacing between accepted check_start pulses: scan time + 3 cycles + handshake time.

## Structure
- Shared package crack_pkg holds:
  - the check_state enum: IDLE=0, READ=1, WAIT=2, CHECK=3, REPORT=4, HOLD=5, ACK_WAIT=6
  - character constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20
  - function is_legal_char(byte)
- No sub-module. A single FSM plus counter, in one module.

## Test plan
- RAM filled with "attack at dawn" padded with spaces to 32 bytes; check_start pulse → test_finish in cycle 97, valid=1, invalid=0, bad_index=0; with crack_ack raised 2 cycles later, valid falls on the next edge.
- Byte 0=0x41 ('A') → test_finish in cycle 4, invalid=1, bad_index=0, rd_addr never exceeds 0.
- Byte 31=0x7B, all others 'z' → invalid at cycle 97, bad_index=31.
- Boundary characters 0x60, 0x61, 0x7A, 0x7B, 0x1F, 0x20, 0x21, each placed at byte 5 → only 0x61, 0x7A and 0x20 are accepted as legal.
- Second check_start during a scan, and crack_ack held high from cycle 1 → the pulse is ignored, the report is unaffected, and HOLD exits on the first crack_ack edge after REPORT.
- nreset asserted at cycle 40 of a scan, then deasserted → IDLE with all outputs 0; a new check_start gives a full 97-cycle scan.
